// File: rtl/atconv_pkg.sv
// ============================================================================
// Module      : atconv_pkg
// Description : Shared widths, layer-1 geometry and the streamer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package atconv_pkg;

    localparam int DATA_W       = 13;
    localparam int ADDR_W       = 12;
    localparam int L1_NUM_PIX   = 1024;
    localparam int L1_BASE_ADDR = 0;
    localparam int GAP_ACC_W    = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/l1_stream_gap_if.sv
// ============================================================================
// Module      : l1_stream_gap_if
// Description : Layer-memory read port plus valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_stream_gap_if;
    import atconv_pkg::*;

    logic              crd;
    logic              csel;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output crd, csel, caddr_rd, out_valid, out_data, out_last,
        input  cdata_rd, out_ready
    );

    modport slave (
        input  crd, csel, caddr_rd, out_valid, out_data, out_last,
        output cdata_rd, out_ready
    );

endinterface

`default_nettype wire

// File: rtl/l1_stream_gap_fifo.sv
// ============================================================================
// Module      : l1_fifo
// Description : Power-of-two circular buffer with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  wire                     clk,
    input  wire                     reset,
    input  wire                     push_i,
    input  wire [WIDTH-1:0]         data_i,
    input  wire                     pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && (count_q != (PTR_W+1)'(DEPTH));

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/l1_stream_gap.sv
// ============================================================================
// Module      : l1_stream_gap
// Description : Streams layer-1 memory words out through a small FIFO with
//               credit-limited reads; optional global average (L1_STREAM_GAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_stream_gap
    import atconv_pkg::*;
#(
    parameter int NUM_PIX    = L1_NUM_PIX,
    parameter int FIFO_DEPTH = 4,
    parameter int L1_BASE    = L1_BASE_ADDR
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start_i,
    output logic                busy_o,
    output logic                done_o,
`ifdef L1_STREAM_GAP_EN
    output logic                gap_valid_o,
    output logic [DATA_W-1:0]   gap_data_o,
`endif
    l1_stream_gap_if.master     bus
);

    localparam int IDX_W = $clog2(NUM_PIX) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rd_pend_q;
    logic               last_pend_q;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W:0]     w_occupancy;
    logic [DATA_W:0]    w_head;
    logic               w_empty;
    logic               w_issue;
    logic               w_last_rd;
    logic               w_pop;

    // Credit check counts the read already in flight so a return always fits.
    assign w_occupancy = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
    assign w_issue     = (state_q == ST_RUN) && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_rd   = (idx_q == IDX_W'(NUM_PIX - 1));
    assign w_pop       = !w_empty && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rd_pend_q   <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_pend_q   <= w_issue;
            last_pend_q <= w_issue && w_last_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (w_last_rd) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head[DATA_W]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    l1_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rd_pend_q),
        .data_i  ({last_pend_q, bus.cdata_rd}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_fifo_count),
        .empty_o (w_empty)
    );

    assign bus.crd       = w_issue;
    assign bus.csel      = 1'b1;
    assign bus.caddr_rd  = w_issue ? (ADDR_W'(L1_BASE) + ADDR_W'(idx_q)) : '0;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign bus.out_last  = !w_empty && w_head[DATA_W];
    assign busy_o        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o        = (state_q == ST_DONE);

`ifdef L1_STREAM_GAP_EN
    localparam int LOG2_PIX = $clog2(NUM_PIX);

    logic [GAP_ACC_W-1:0] acc_q;
    logic [DATA_W-1:0]    gap_q;
    logic [GAP_ACC_W:0]   w_rounded;

    assign w_rounded = {1'b0, acc_q} + (GAP_ACC_W+1)'(NUM_PIX / 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            gap_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                acc_q <= '0;
            end else if (rd_pend_q) begin
                acc_q <= acc_q + GAP_ACC_W'(bus.cdata_rd);
            end
            if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
                gap_q <= DATA_W'(w_rounded >> LOG2_PIX);
            end
        end
    end

    assign gap_valid_o = (state_q == ST_DONE);
    assign gap_data_o  = gap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_stream_gap.sv
// ============================================================================
// Module      : tb_l1_stream_gap
// Description : Randomized directed bench for l1_stream_gap with a word-order,
//               timing and average reference model (optional L1_STREAM_GAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l1_stream_gap;
    import atconv_pkg::*;

    localparam int NUM_PIX    = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int L1_BASE    = 0;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef L1_STREAM_GAP_EN
    logic              gap_valid;
    logic [DATA_W-1:0] gap_data;
`endif

    l1_stream_gap_if bus();

    l1_stream_gap #(
        .NUM_PIX    (NUM_PIX),
        .FIFO_DEPTH (FIFO_DEPTH),
        .L1_BASE    (L1_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
`ifdef L1_STREAM_GAP_EN
        .gap_valid_o (gap_valid),
        .gap_data_o  (gap_data),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [4096];
    always @(posedge clk) begin
        if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int pass_id = 0;

    // Monitor state, written only by the negedge process below.
    int mon_pass = -1;
    int acc_cnt, rd_cnt, done_cnt, bad_data, bad_last, bad_addr, unstable;
    int first_acc, last_acc, done_cyc;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    logic [31:0] gap_seen, gapv_seen;

    always @(negedge clk) begin
        if (pass_id != mon_pass) begin
            mon_pass = pass_id;
            acc_cnt = 0; rd_cnt = 0; done_cnt = 0;
            bad_data = 0; bad_last = 0; bad_addr = 0; unstable = 0;
            first_acc = -1; last_acc = -1; done_cyc = -1;
            gap_seen = '0; gapv_seen = '0;
        end
        if (prev_v && !prev_r &&
            (!bus.out_valid || bus.out_data !== prev_d || bus.out_last !== prev_l))
            unstable++;
        if (bus.out_valid && bus.out_ready) begin
            if (acc_cnt >= NUM_PIX || bus.out_data !== mem[L1_BASE + acc_cnt]) bad_data++;
            if (bus.out_last !== (acc_cnt == NUM_PIX - 1)) bad_last++;
            if (acc_cnt == 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
        end
        if (bus.crd) begin
            if (bus.caddr_rd !== ADDR_W'(L1_BASE + rd_cnt)) bad_addr++;
            rd_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef L1_STREAM_GAP_EN
            gap_seen  = 32'(gap_data);
            gapv_seen = 32'(gap_valid);
`endif
        end
        prev_v = bus.out_valid;
        prev_r = bus.out_ready;
        prev_d = bus.out_data;
        prev_l = bus.out_last;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_model();
        longint sum = 0;
        for (int i = 0; i < NUM_PIX; i++) sum += longint'(mem[L1_BASE + i]);
        return int'((sum + NUM_PIX / 2) / NUM_PIX);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_crd"},   32'(bus.crd), 0);
        chk({tag, "_csel"},  32'(bus.csel), 1);
        chk({tag, "_addr"},  32'(bus.caddr_rd), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data"},  32'(bus.out_data), 0);
        chk({tag, "_last"},  32'(bus.out_last), 0);
`ifdef L1_STREAM_GAP_EN
        chk({tag, "_gapv"},  32'(gap_valid), 0);
        chk({tag, "_gapd"},  32'(gap_data), 0);
`endif
    endtask

    task automatic start_pass();
        pass_id++;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random
    task automatic drive(input int mode, input int abort_at, input bit extra_start);
        int n = 0;
        while (done_cnt == 0 && n < 20000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            start = extra_start && (n == 5 || n == 600);
            if (abort_at > 0 && acc_cnt == abort_at) break;
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int mode);
        repeat (4) tick();
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_words"},    acc_cnt, NUM_PIX);
        chk({tag, "_reads"},    rd_cnt, NUM_PIX);
        chk({tag, "_bad_data"}, bad_data, 0);
        chk({tag, "_bad_last"}, bad_last, 0);
        chk({tag, "_bad_addr"}, bad_addr, 0);
        chk({tag, "_unstable"}, unstable, 0);
        chk({tag, "_idle"},     32'(busy), 0);
        chk({tag, "_done_lat"}, done_cyc - last_acc, 1);
        if (mode == 0) chk({tag, "_burst"}, last_acc - first_acc, NUM_PIX - 1);
`ifdef L1_STREAM_GAP_EN
        chk({tag, "_gapv"}, gapv_seen, 1);
        chk({tag, "_gapd"}, gap_seen, gap_model());
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        tick();
        tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();

        // All words equal, consumer always ready: back-to-back stream.
        for (int i = 0; i < 4096; i++) mem[i] = 13'h0010;
        start_pass();
        chk("a_busy", 32'(busy), 1);
        drive(0, 0, 1'b0);
        check_pass("a", 0);

        // Ramp data, ready toggling.
        for (int i = 0; i < 4096; i++) mem[i] = 13'(i);
        bus.out_ready = 1'b0;
        start_pass();
        drive(1, 0, 1'b0);
        check_pass("b", 1);

        // Random data, consumer stalled for 100 cycles.
        for (int i = 0; i < 4096; i++) mem[i] = 13'($urandom);
        bus.out_ready = 1'b0;
        start_pass();
        repeat (100) tick();
        chk("c_stall_reads", rd_cnt, FIFO_DEPTH);
        chk("c_stall_addr",  bad_addr, 0);
        chk("c_stall_crd",   32'(bus.crd), 0);
        chk("c_stall_valid", 32'(bus.out_valid), 1);
        chk("c_stall_data",  32'(bus.out_data), 32'(mem[L1_BASE]));
        chk("c_stall_stable", unstable, 0);
        drive(2, 0, 1'b0);
        check_pass("c", 2);

        // Reset mid-pass after the 300th word, then a clean restart.
        for (int i = 0; i < 4096; i++) mem[i] = 13'(i);
        start_pass();
        drive(2, 300, 1'b0);
        chk("d_abort_words", acc_cnt, 300);
        chk("d_abort_data",  bad_data, 0);
        reset = 1'b1;
        #1;
        check_reset_vals("d_rst");
        tick();
        tick();
        reset = 1'b0;
        pass_id++;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("d_quiet_reads", rd_cnt, 0);
        chk("d_quiet_words", acc_cnt, 0);
        chk("d_quiet_done",  done_cnt, 0);
        start_pass();
        drive(1, 0, 1'b0);
        check_pass("d", 1);

        // Start pulses while busy are ignored; single non-zero word for the average.
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[L1_BASE] = 13'h0200;
        start_pass();
        drive(2, 0, 1'b1);
        check_pass("e", 2);
        repeat (10) tick();
        chk("e_no_restart", rd_cnt, NUM_PIX);
        chk("e_single_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
